// File: rtl/apb_regfile_pkg.sv
// Shared types and helpers for the APB register file.
package apb_regfile_pkg;

    typedef enum logic {IDLE, ACCESS} apb_state_t;

    // Wait-state counter width; covers WAIT_STATES up to 15.
    localparam int unsigned WAIT_CNT_W = 4;

    function automatic int unsigned strb_w(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/apb_regfile_wait_ctr.sv
// Loadable down-counter that paces APB wait states; zero means ready.
module apb_regfile_wait_ctr #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/apb_regfile.sv
// APB4 slave register file with byte strobes, wait states, error response,
// hardware-sourced read-only registers and per-register write pulses.
module apb_regfile
    import apb_regfile_pkg::*;
#(
    parameter int unsigned         ADDR_WIDTH  = 8,
    parameter int unsigned         DATA_WIDTH  = 32,
    parameter int unsigned         NUM_REGS    = 18,
    parameter int unsigned         WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    input  logic [DATA_WIDTH/8-1:0]        pstrb,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pready,
    output logic                           pslverr,
    output logic [NUM_REGS*DATA_WIDTH-1:0] ctrl_q,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int unsigned      IDX_W      = ADDR_WIDTH - 2;
    localparam int unsigned      SPAN       = 2 ** IDX_W;
    localparam int unsigned      STRB_W     = strb_w(DATA_WIDTH);
    localparam logic [IDX_W:0]   NUM_REGS_L = (IDX_W + 1)'(NUM_REGS);
    localparam logic [SPAN-1:0]  RO_EXT     = SPAN'(RO_MASK);

    apb_state_t            state_q, state_d;
    logic [IDX_W-1:0]      idx_q;
    logic                  wr_q;
    logic                  err_q;
    logic [IDX_W-1:0]      idx_in;
    logic                  setup;
    logic                  err_in;
    logic                  access_en;
    logic                  cnt_en;
    logic                  cnt_zero;
    logic                  commit;
    logic [NUM_REGS-1:0]   wr_sel;
    logic [DATA_WIDTH-1:0] reg_val [NUM_REGS];
    logic [DATA_WIDTH-1:0] rd_mux;
    logic                  unused_ok;

    assign idx_in    = paddr[ADDR_WIDTH-1:2];
    assign setup     = (state_q == IDLE) && psel && !penable;
    assign err_in    = ({1'b0, idx_in} >= NUM_REGS_L) || (pwrite && RO_EXT[idx_in]);
    assign access_en = (state_q == ACCESS) && psel && penable;
    assign cnt_en    = access_en && !cnt_zero;
    assign commit    = access_en && cnt_zero;

    apb_regfile_wait_ctr #(
        .WIDTH(WAIT_CNT_W)
    ) u_wait (
        .clk     (clk),
        .rst     (rst),
        .load    (setup),
        .load_val(WAIT_CNT_W'(WAIT_STATES)),
        .en      (cnt_en),
        .zero    (cnt_zero)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (setup) state_d = ACCESS;
            ACCESS:  if (!psel || commit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            wr_pulse <= '0;
        end else begin
            state_q  <= state_d;
            wr_pulse <= wr_sel;
            if (setup) begin
                idx_q <= idx_in;
                wr_q  <= pwrite;
                err_q <= err_in;
            end
        end
    end

    always_comb begin
        wr_sel = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (commit && wr_q && !err_q && (idx_q == IDX_W'(i))) wr_sel[i] = 1'b1;
        end
    end

    // Read-only registers have no storage; their value is the live status slice.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (RO_MASK[i]) begin : g_ro
            assign reg_val[i] = status_in[i*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_rw
            logic [DATA_WIDTH-1:0] q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    q <= '0;
                end else if (wr_sel[i]) begin
                    for (int unsigned b = 0; b < STRB_W; b++) begin
                        if (pstrb[b]) q[b*8 +: 8] <= pwdata[b*8 +: 8];
                    end
                end
            end
            assign reg_val[i] = q;
        end
        assign ctrl_q[i*DATA_WIDTH +: DATA_WIDTH] = reg_val[i];
    end

    always_comb begin
        rd_mux = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (idx_q == IDX_W'(i)) rd_mux = reg_val[i];
        end
    end

    assign pready    = (state_q == ACCESS) && cnt_zero;
    assign pslverr   = pready && err_q;
    assign prdata    = (pready && !wr_q && !err_q) ? rd_mux : '0;

    // Status slices of RW registers and the byte-offset address bits are don't-care.
    assign unused_ok = ^{status_in, paddr[1:0]};

endmodule

// File: tb/tb_apb_regfile.sv
// Directed self-checking bench: one zero-wait and one 3-wait instance, reg 5 read-only.
module tb_apb_regfile;

    logic         clk;
    logic         rst;
    logic [7:0]   paddr;
    logic         psel0, psel3;
    logic         penable;
    logic         pwrite;
    logic [31:0]  pwdata;
    logic [3:0]   pstrb;
    logic [575:0] status_in;
    logic [31:0]  prdata0, prdata3;
    logic         pready0, pready3;
    logic         pslverr0, pslverr3;
    logic [575:0] ctrl0, ctrl3;
    logic [17:0]  pulse0, pulse3;

    int checks   = 0;
    int failures = 0;

    apb_regfile #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .NUM_REGS   (18),
        .WAIT_STATES(0),
        .RO_MASK    (18'h00020)
    ) dut0 (
        .clk(clk), .rst(rst), .paddr(paddr), .psel(psel0), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata0),
        .pready(pready0), .pslverr(pslverr0), .ctrl_q(ctrl0),
        .status_in(status_in), .wr_pulse(pulse0)
    );

    apb_regfile #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .NUM_REGS   (18),
        .WAIT_STATES(3),
        .RO_MASK    (18'h00020)
    ) dut3 (
        .clk(clk), .rst(rst), .paddr(paddr), .psel(psel3), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata3),
        .pready(pready3), .pslverr(pslverr3), .ctrl_q(ctrl3),
        .status_in(status_in), .wr_pulse(pulse3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Full transfer starting right now (caller is at posedge+1); returns at commit edge +1.
    task automatic xfer(input bit u3, input logic [7:0] addr, input bit wr,
                        input logic [31:0] data, input logic [3:0] strb,
                        output logic [31:0] rd, output logic err, output int waits);
        psel0   = !u3;
        psel3   = u3;
        penable = 1'b0;
        paddr   = addr;
        pwrite  = wr;
        pwdata  = data;
        pstrb   = strb;
        @(posedge clk);
        #1;
        penable = 1'b1;
        waits = 0;
        rd    = '0;
        err   = 1'b0;
        forever begin
            @(negedge clk);
            if (u3 ? pready3 : pready0) begin
                rd  = u3 ? prdata3 : prdata0;
                err = u3 ? pslverr3 : pslverr0;
                break;
            end
            waits++;
            if (waits > 20) begin
                checks++;
                failures++;
                $display("FAIL xfer_timeout addr=%h got=no_pready required=pready_within_20", addr);
                break;
            end
        end
        @(posedge clk);
        #1;
        psel0   = 1'b0;
        psel3   = 1'b0;
        penable = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        checks++; if (pready0 !== 1'b0) begin failures++; $display("FAIL reset_pready0 got=%b exp=0", pready0); end
        checks++; if (prdata0 !== 32'h0) begin failures++; $display("FAIL reset_prdata0 got=%h exp=0", prdata0); end
        checks++; if (pslverr0 !== 1'b0) begin failures++; $display("FAIL reset_pslverr0 got=%b exp=0", pslverr0); end
        checks++; if (pulse0 !== 18'h0) begin failures++; $display("FAIL reset_pulse0 got=%h exp=0", pulse0); end
        checks++; if (ctrl0[0 +: 160] !== 160'h0) begin failures++; $display("FAIL reset_ctrl0 got=%h exp=0", ctrl0[0 +: 160]); end

        // Reset hits while dut3 is mid-write to 0x04 in its wait states.
        psel3 = 1'b1; penable = 1'b0; paddr = 8'h04; pwrite = 1'b1;
        pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
        idle(1);
        penable = 1'b1;
        idle(1);
        rst = 1'b1;
        idle(2);
        rst = 1'b0; psel3 = 1'b0; penable = 1'b0;
        checks++; if (pready3 !== 1'b0) begin failures++; $display("FAIL midrst_pready got=%b exp=0", pready3); end
        checks++; if (pulse3 !== 18'h0) begin failures++; $display("FAIL midrst_pulse got=%h exp=0", pulse3); end
        idle(5);
        checks++; if (ctrl3[32 +: 32] !== 32'h0) begin failures++; $display("FAIL midrst_reg1 got=%h exp=0", ctrl3[32 +: 32]); end
        checks++; if (pulse3 !== 18'h0) begin failures++; $display("FAIL midrst_pulse_late got=%h exp=0", pulse3); end
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic err; int waits;
        xfer(1'b0, 8'h08, 1'b1, 32'hDEAD_BEEF, 4'hF, rd, err, waits);
        checks++; if (waits !== 0) begin failures++; $display("FAIL wr0_waits got=%0d exp=0", waits); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL wr0_err got=%b exp=0", err); end
        checks++; if (pulse0 !== 18'h00004) begin failures++; $display("FAIL wr0_pulse got=%h exp=00004", pulse0); end
        checks++; if (ctrl0[64 +: 32] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr0_reg2 got=%h exp=deadbeef", ctrl0[64 +: 32]); end
        idle(1);
        checks++; if (pulse0 !== 18'h0) begin failures++; $display("FAIL wr0_pulse_len got=%h exp=0", pulse0); end
        xfer(1'b0, 8'h08, 1'b0, 32'h0, 4'h0, rd, err, waits);
        checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd0_data got=%h exp=deadbeef", rd); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rd0_err got=%b exp=0", err); end
        checks++; if (waits !== 0) begin failures++; $display("FAIL rd0_waits got=%0d exp=0", waits); end
        checks++; if (prdata0 !== 32'h0) begin failures++; $display("FAIL rd0_prdata_idle got=%h exp=0", prdata0); end
        idle(1);
    endtask

    task automatic test_strobe();
        logic [31:0] rd; logic err; int waits;
        xfer(1'b0, 8'h08, 1'b1, 32'h1122_3344, 4'b0101, rd, err, waits);
        checks++; if (ctrl0[64 +: 32] !== 32'hDE22_BE44) begin failures++; $display("FAIL strb_reg2 got=%h exp=de22be44", ctrl0[64 +: 32]); end
        idle(1);
        xfer(1'b0, 8'h08, 1'b1, 32'h0000_0000, 4'b0000, rd, err, waits);
        checks++; if (pulse0 !== 18'h00004) begin failures++; $display("FAIL strb0_pulse got=%h exp=00004", pulse0); end
        checks++; if (ctrl0[64 +: 32] !== 32'hDE22_BE44) begin failures++; $display("FAIL strb0_reg2 got=%h exp=de22be44", ctrl0[64 +: 32]); end
        idle(1);
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; logic err; int waits;
        xfer(1'b1, 8'h0C, 1'b1, 32'h1234_5678, 4'hF, rd, err, waits);
        checks++; if (waits !== 3) begin failures++; $display("FAIL ws_wr_waits got=%0d exp=3", waits); end
        checks++; if (pulse3 !== 18'h00008) begin failures++; $display("FAIL ws_wr_pulse got=%h exp=00008", pulse3); end
        checks++; if (ctrl3[96 +: 32] !== 32'h1234_5678) begin failures++; $display("FAIL ws_reg3 got=%h exp=12345678", ctrl3[96 +: 32]); end
        idle(1);
        xfer(1'b1, 8'h0C, 1'b0, 32'h0, 4'h0, rd, err, waits);
        checks++; if (waits !== 3) begin failures++; $display("FAIL ws_rd_waits got=%0d exp=3", waits); end
        checks++; if (rd !== 32'h1234_5678) begin failures++; $display("FAIL ws_rd_data got=%h exp=12345678", rd); end
        idle(1);

        // Abort: psel drops on the second access cycle of a write.
        psel3 = 1'b1; penable = 1'b0; paddr = 8'h10; pwrite = 1'b1;
        pwdata = 32'hAAAA_5555; pstrb = 4'hF;
        idle(1);
        penable = 1'b1;
        @(negedge clk);
        checks++; if (pready3 !== 1'b0) begin failures++; $display("FAIL abort_pready_acc1 got=%b exp=0", pready3); end
        idle(1);
        psel3 = 1'b0; penable = 1'b0;
        idle(1);
        checks++; if (pready3 !== 1'b0) begin failures++; $display("FAIL abort_pready got=%b exp=0", pready3); end
        checks++; if (pulse3 !== 18'h0) begin failures++; $display("FAIL abort_pulse got=%h exp=0", pulse3); end
        idle(3);
        checks++; if (ctrl3[128 +: 32] !== 32'h0) begin failures++; $display("FAIL abort_reg4 got=%h exp=0", ctrl3[128 +: 32]); end
        xfer(1'b1, 8'h10, 1'b0, 32'h0, 4'h0, rd, err, waits);
        checks++; if (waits !== 3) begin failures++; $display("FAIL abort_next_waits got=%0d exp=3", waits); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL abort_next_data got=%h exp=0", rd); end
        idle(1);
    endtask

    task automatic test_error();
        logic [31:0] rd; logic err; int waits;
        xfer(1'b0, 8'h48, 1'b0, 32'h0, 4'h0, rd, err, waits);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_oob_slverr got=%b exp=1", err); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL err_oob_data got=%h exp=0", rd); end
        checks++; if (waits !== 0) begin failures++; $display("FAIL err_oob_waits got=%0d exp=0", waits); end
        idle(1);
        xfer(1'b0, 8'h14, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, err, waits);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_ro_slverr got=%b exp=1", err); end
        checks++; if (pulse0 !== 18'h0) begin failures++; $display("FAIL err_ro_pulse got=%h exp=0", pulse0); end
        idle(1);
        xfer(1'b0, 8'h14, 1'b0, 32'h0, 4'h0, rd, err, waits);
        checks++; if (rd !== 32'h0000_A5A5) begin failures++; $display("FAIL ro_read_data got=%h exp=0000a5a5", rd); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL ro_read_err got=%b exp=0", err); end
        idle(1);
        xfer(1'b1, 8'h48, 1'b1, 32'h1, 4'hF, rd, err, waits);
        checks++; if (err !== 1'b1 || waits !== 3) begin failures++; $display("FAIL err_oob3 got=err%b/w%0d exp=err1/w3", err, waits); end
        checks++; if (pulse3 !== 18'h0) begin failures++; $display("FAIL err_oob3_pulse got=%h exp=0", pulse3); end
        idle(1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic err; int waits;
        xfer(1'b0, 8'h00, 1'b1, 32'hCAFE_F00D, 4'hF, rd, err, waits);
        xfer(1'b0, 8'h00, 1'b0, 32'h0, 4'h0, rd, err, waits);
        checks++; if (rd !== 32'hCAFE_F00D) begin failures++; $display("FAIL b2b_data got=%h exp=cafef00d", rd); end
        checks++; if (waits !== 0) begin failures++; $display("FAIL b2b_waits got=%0d exp=0", waits); end
        checks++; if (ctrl0[0 +: 32] !== 32'hCAFE_F00D) begin failures++; $display("FAIL b2b_reg0 got=%h exp=cafef00d", ctrl0[0 +: 32]); end
        idle(1);
    endtask

    initial begin
        rst     = 1'b1;
        paddr   = '0;
        psel0   = 1'b0;
        psel3   = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        pwdata  = '0;
        pstrb   = '0;
        status_in = '0;
        status_in[5*32 +: 32] = 32'h0000_A5A5;
        @(posedge clk);
        #1;
        test_reset();
        test_write_read();
        test_strobe();
        test_wait_states();
        test_error();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
